// File: rtl/alu_addsub_pipe_if.sv
// Handshake and operand/result bundle for the pipelined add/subtract ALU.
// The master drives operands and consumes results. The slave is the ALU.
interface alu_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             n;
  logic             v;
  logic             z;
  logic             c;
  logic             clr_sticky;
  logic             ovf_sticky;

  modport master (
    output in_valid, op, a, b, out_ready, clr_sticky,
    input  in_ready, out_valid, s, n, v, z, c, ovf_sticky
  );

  modport slave (
    input  in_valid, op, a, b, out_ready, clr_sticky,
    output in_ready, out_valid, s, n, v, z, c, ovf_sticky
  );
endinterface

// File: rtl/alu_addsub_pipe.sv
// Pipelined two's-complement add/subtract ALU with optional saturation.
// A subtract reuses the adder as a + ~b + 1.
// With PIPE=2, the lower half-sum and its carry are registered first.
// The upper half, saturation and flags are then finished in the output stage.
// The whole pipe advances on one global enable, so a stalled output freezes every stage.
module alu_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 2,
  parameter int SAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_addsub_pipe_if.slave   bus
);
  localparam int H = WIDTH / 2;

  logic             en;
  logic             accept;

  logic [H-1:0]     lo_sum;
  logic             lo_carry;

  logic             fin_valid;
  logic [H-1:0]     fin_lo_sum;
  logic             fin_lo_carry;
  logic [H-1:0]     fin_a_hi;
  logic [H-1:0]     fin_b_hi;
  logic [1:0]       fin_op;

  logic [H-1:0]     b_hi_eff;
  logic [H-1:0]     hi_sum;
  logic             raw_c;
  logic             raw_v;
  logic [WIDTH-1:0] fin_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             n_q, n_d;
  logic             v_q, v_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  assign en       = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & en;
  assign bus.in_ready = en;

  // Lower half of the adder, with the subtract carry-in injected at bit 0.
  always_comb begin
    logic [H-1:0] b_lo_eff;
    b_lo_eff = bus.op[0] ? ~bus.b[H-1:0] : bus.b[H-1:0];
    {lo_carry, lo_sum} = {1'b0, bus.a[H-1:0]} + {1'b0, b_lo_eff}
                       + {{H{1'b0}}, bus.op[0]};
  end

  generate
    if (PIPE == 2) begin : g_two_stage
      logic         st1_valid_q, st1_valid_d;
      logic [H-1:0] st1_lo_sum_q, st1_lo_sum_d;
      logic         st1_lo_carry_q, st1_lo_carry_d;
      logic [H-1:0] st1_a_hi_q, st1_a_hi_d;
      logic [H-1:0] st1_b_hi_q, st1_b_hi_d;
      logic [1:0]   st1_op_q, st1_op_d;

      // Stage 1 captures new operands only on acceptance.
      // Its valid bit follows upstream whenever the pipe advances, so bubbles propagate.
      always_comb begin
        st1_valid_d    = en ? bus.in_valid : st1_valid_q;
        st1_lo_sum_d   = accept ? lo_sum : st1_lo_sum_q;
        st1_lo_carry_d = accept ? lo_carry : st1_lo_carry_q;
        st1_a_hi_d     = accept ? bus.a[WIDTH-1:H] : st1_a_hi_q;
        st1_b_hi_d     = accept ? bus.b[WIDTH-1:H] : st1_b_hi_q;
        st1_op_d       = accept ? bus.op : st1_op_q;
      end

      // Stage 1 register bank.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st1_valid_q    <= 1'b0;
          st1_lo_sum_q   <= '0;
          st1_lo_carry_q <= 1'b0;
          st1_a_hi_q     <= '0;
          st1_b_hi_q     <= '0;
          st1_op_q       <= '0;
        end else begin
          st1_valid_q    <= st1_valid_d;
          st1_lo_sum_q   <= st1_lo_sum_d;
          st1_lo_carry_q <= st1_lo_carry_d;
          st1_a_hi_q     <= st1_a_hi_d;
          st1_b_hi_q     <= st1_b_hi_d;
          st1_op_q       <= st1_op_d;
        end
      end

      assign fin_valid    = st1_valid_q;
      assign fin_lo_sum   = st1_lo_sum_q;
      assign fin_lo_carry = st1_lo_carry_q;
      assign fin_a_hi     = st1_a_hi_q;
      assign fin_b_hi     = st1_b_hi_q;
      assign fin_op       = st1_op_q;
    end else begin : g_one_stage
      assign fin_valid    = bus.in_valid;
      assign fin_lo_sum   = lo_sum;
      assign fin_lo_carry = lo_carry;
      assign fin_a_hi     = bus.a[WIDTH-1:H];
      assign fin_b_hi     = bus.b[WIDTH-1:H];
      assign fin_op       = bus.op;
    end
  endgenerate

  // Upper half of the adder, overflow detection and clamping.
  // Overflow is judged against the effective B operand.
  // That makes one rule cover both add and subtract.
  always_comb begin
    b_hi_eff = fin_op[0] ? ~fin_b_hi : fin_b_hi;
    {raw_c, hi_sum} = {1'b0, fin_a_hi} + {1'b0, b_hi_eff}
                    + {{H{1'b0}}, fin_lo_carry};
    raw_v = (fin_a_hi[H-1] == b_hi_eff[H-1]) && (hi_sum[H-1] != fin_a_hi[H-1]);
    fin_s = {hi_sum, fin_lo_sum};
    if ((SAT != 0) && fin_op[1] && raw_v) begin
      fin_s = fin_a_hi[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Output stage loads a finished result when the pipe advances.
  // The sticky overflow is set by a transferring overflowed result.
  // A set wins over a simultaneous clear.
  always_comb begin
    logic load;
    load         = en & fin_valid;
    out_valid_d  = en ? fin_valid : out_valid_q;
    s_d          = load ? fin_s : s_q;
    n_d          = load ? fin_s[WIDTH-1] : n_q;
    z_d          = load ? (fin_s == '0) : z_q;
    v_d          = load ? raw_v : v_q;
    c_d          = load ? raw_c : c_q;
    ovf_sticky_d = (out_valid_q & bus.out_ready & v_q)
                 | (ovf_sticky_q & ~bus.clr_sticky);
  end

  // Output and sticky register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      s_q          <= '0;
      n_q          <= 1'b0;
      v_q          <= 1'b0;
      z_q          <= 1'b0;
      c_q          <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      s_q          <= s_d;
      n_q          <= n_d;
      v_q          <= v_d;
      z_q          <= z_d;
      c_q          <= c_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.s          = s_q;
  assign bus.n          = n_q;
  assign bus.v          = v_q;
  assign bus.z          = z_q;
  assign bus.c          = c_q;
  assign bus.ovf_sticky = ovf_sticky_q;
endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Self-checking bench for alu_addsub_pipe (WIDTH=16, PIPE=2, SAT=1).
// Expected results come from a signed-integer arithmetic model.
module tb_alu_addsub_pipe;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_addsub_pipe_if #(.WIDTH(16)) bus ();

  alu_addsub_pipe #(.WIDTH(16), .PIPE(2), .SAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        n;
    logic        v;
    logic        z;
    logic        c;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  // Reference: exact signed arithmetic, then clamp or wrap to 16 bits.
  function automatic res_t model(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b);
    res_t        r;
    int          sa, sb, sum;
    int unsigned ua, ub;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ua  = a;
    ub  = b;
    sum = op[0] ? sa - sb : sa + sb;
    r.v = (sum > 32767) || (sum < -32768);
    r.c = op[0] ? (ua >= ub) : ((ua + ub) > 65535);
    if (op[1] && r.v) r.s = (sum > 0) ? 16'h7FFF : 16'h8000;
    else              r.s = sum[15:0];
    r.n = r.s[15];
    r.z = (r.s == 16'h0000);
    return r;
  endfunction

  function automatic logic [15:0] pick_operand();
    logic [15:0] edges [5];
    edges = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  task automatic set_idle();
    bus.in_valid   = 1'b0;
    bus.op         = 2'b00;
    bus.a          = 16'h0;
    bus.b          = 16'h0;
    bus.out_ready  = 1'b1;
    bus.clr_sticky = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    bus.out_ready = 1'b0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if ({bus.s, bus.n, bus.v, bus.z, bus.c} !== 20'h0) begin
      errors++; $display("[TB] FAIL reset_result: got %h expected 00000", {bus.s, bus.n, bus.v, bus.z, bus.c});
    end
    checks++;
    if (bus.ovf_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_sticky: got %b expected 0", bus.ovf_sticky);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL post_reset_idle: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [5];
    logic [15:0] t_a  [5];
    logic [15:0] t_b  [5];
    logic [15:0] t_s  [5];
    logic [3:0]  t_f  [5];
    t_op = '{2'b00,    2'b10,    2'b11,    2'b01,    2'b00};
    t_a  = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h1234, 16'h00FF};
    t_b  = '{16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h0001};
    t_s  = '{16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0100};
    t_f  = '{4'b1100,  4'b0100,  4'b1101,  4'b0011,  4'b0000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op = t_op[i];
      bus.a = t_a[i];
      bus.b = t_b[i];
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL dir%0d_early_valid: got %b expected 0", i, bus.out_valid);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL dir%0d_valid: got %b expected 1", i, bus.out_valid);
      end
      checks++;
      if (bus.s !== t_s[i]) begin
        errors++; $display("[TB] FAIL dir%0d_s: got %h expected %h", i, bus.s, t_s[i]);
      end
      checks++;
      if ({bus.n, bus.v, bus.z, bus.c} !== t_f[i]) begin
        errors++; $display("[TB] FAIL dir%0d_nvzc: got %b expected %b", i, {bus.n, bus.v, bus.z, bus.c}, t_f[i]);
      end
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (bus.ovf_sticky !== 1'b1 || bus.out_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL dir_sticky_set: got sticky=%b valid=%b expected 1/0", bus.ovf_sticky, bus.out_valid);
        end
      end
    end
  endtask

  task automatic test_sticky();
    @(negedge clk);
    bus.clr_sticky = 1'b1;
    @(negedge clk);
    bus.clr_sticky = 1'b0;
    checks++;
    if (bus.ovf_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL sticky_clear: got %b expected 0", bus.ovf_sticky);
    end
    bus.in_valid = 1'b1;
    bus.op = 2'b00;
    bus.a = 16'h7FFF;
    bus.b = 16'h0001;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.ovf_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL sticky_wait: got valid=%b sticky=%b expected 1/0", bus.out_valid, bus.ovf_sticky);
    end
    bus.out_ready = 1'b1;
    bus.clr_sticky = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ovf_sticky !== 1'b1) begin
      errors++; $display("[TB] FAIL sticky_set_wins: got %b expected 1", bus.ovf_sticky);
    end
    @(negedge clk);
    bus.clr_sticky = 1'b0;
    checks++;
    if (bus.ovf_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL sticky_clear_alone: got %b expected 0", bus.ovf_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  p_op [4];
    logic [15:0] p_a  [4];
    logic [15:0] p_b  [4];
    int          sent = 0;
    int          got = 0;
    int          stall_left = -1;
    int          blocked = 0;
    logic        ov, exp_ready, was_stalled = 1'b0;
    logic [19:0] held = '0;
    res_t        e;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      p_op[i] = 2'($urandom);
      p_a[i] = pick_operand();
      p_b[i] = pick_operand();
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      ov = bus.out_valid;
      if (was_stalled) begin
        checks++;
        if ({bus.s, bus.n, bus.v, bus.z, bus.c} !== held || ov !== 1'b1) begin
          errors++; $display("[TB] FAIL b2b_hold: got %h valid=%b expected %h valid=1", {bus.s, bus.n, bus.v, bus.z, bus.c}, ov, held);
        end
      end
      if (ov && stall_left < 0) stall_left = 3;
      bus.out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      if (stall_left > 0) stall_left--;
      if (sent < 4) begin
        bus.in_valid = 1'b1;
        bus.op = p_op[sent];
        bus.a = p_a[sent];
        bus.b = p_b[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      exp_ready = !ov || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_ready) begin
        errors++; $display("[TB] FAIL b2b_in_ready: got %b expected %b", bus.in_ready, exp_ready);
      end
      if (bus.in_valid && !exp_ready) blocked++;
      if (bus.in_valid && exp_ready) begin
        exp_q.push_back(model(bus.op, bus.a, bus.b));
        sent++;
      end
      if (ov && bus.out_ready) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if ({bus.s, bus.n, bus.v, bus.z, bus.c} !== e) begin
          errors++; $display("[TB] FAIL b2b_result%0d: got %h expected %h", got, {bus.s, bus.n, bus.v, bus.z, bus.c}, e);
        end
      end
      was_stalled = ov && !bus.out_ready;
      held = {bus.s, bus.n, bus.v, bus.z, bus.c};
    end
    checks++;
    if (got != 4 || exp_q.size() != 0 || blocked == 0) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d results (%0d left, %0d blocked) expected 4 (0 left, >0 blocked)", got, exp_q.size(), blocked);
    end
  endtask

  task automatic test_random();
    int          got = 0;
    int          sent = 0;
    logic        ov, exp_ready, was_stalled = 1'b0;
    logic [19:0] held = '0;
    res_t        e;
    exp_q.delete();
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge clk);
      ov = bus.out_valid;
      if (was_stalled) begin
        checks++;
        if ({bus.s, bus.n, bus.v, bus.z, bus.c} !== held || ov !== 1'b1) begin
          errors++; $display("[TB] FAIL rand_hold: got %h valid=%b expected %h valid=1", {bus.s, bus.n, bus.v, bus.z, bus.c}, ov, held);
        end
      end
      if (cyc < 300) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.op = 2'($urandom);
        bus.a = pick_operand();
        bus.b = pick_operand();
        bus.out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
      end
      #1;
      exp_ready = !ov || bus.out_ready;
      checks++;
      if (bus.in_ready !== exp_ready) begin
        errors++; $display("[TB] FAIL rand_in_ready: got %b expected %b", bus.in_ready, exp_ready);
      end
      if (bus.in_valid && exp_ready) begin
        exp_q.push_back(model(bus.op, bus.a, bus.b));
        sent++;
      end
      if (ov && bus.out_ready) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL rand_extra: got result %h expected none", bus.s);
        end else begin
          e = exp_q.pop_front();
          if ({bus.s, bus.n, bus.v, bus.z, bus.c} !== e) begin
            errors++; $display("[TB] FAIL rand_result%0d: got %h expected %h", got, {bus.s, bus.n, bus.v, bus.z, bus.c}, e);
          end
        end
      end
      was_stalled = ov && !bus.out_ready;
      held = {bus.s, bus.n, bus.v, bus.z, bus.c};
    end
    checks++;
    if (got != sent || exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL rand_count: got %0d results expected %0d", got, sent);
    end
  endtask

  task automatic test_reset_midflight();
    res_t e;
    exp_q.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = 2'b00;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.a = 16'h3333;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_pre_valid: got %b expected 1", bus.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.s !== 16'h0 || bus.in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_immediate: got valid=%b s=%h ready=%b expected 0/0000/1", bus.out_valid, bus.s, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL rstmid_stale%0d: got valid=%b ready=%b expected 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b1;
    bus.op = 2'b01;
    bus.a = 16'h0005;
    bus.b = 16'h0009;
    e = model(2'b01, 16'h0005, 16'h0009);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_latency: got %b expected 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.s, bus.n, bus.v, bus.z, bus.c} !== e) begin
      errors++; $display("[TB] FAIL rstmid_result: got valid=%b %h expected 1 %h", bus.out_valid, {bus.s, bus.n, bus.v, bus.z, bus.c}, e);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_sticky();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "[TB] simulation timed out");
  end
endmodule

// File: doc/alu_addsub_pipe.md
ALU_ADDSUB_PIPE -- requirements
Module: alu_addsub_pipe

Interface
- REQ-001: Parameter WIDTH, default 16, operand/result width in bits; legal values are even and at least 4.
- REQ-002: Parameter PIPE, default 2, number of register stages (legal 1 or 2).
- REQ-003: Parameter SAT, default 1, enables saturating modes (0 = disabled).
- REQ-004: clk  input  1  single clock; all state updates on rising edge.
- REQ-005: rst  input  1  reset, asynchronous, active-high.
- REQ-006: in_valid  input  1  operand set presented.
- REQ-007: in_ready  output  1  block accepts operands this cycle.
- REQ-008: op  input  2  00 add, 01 sub, 10 add-saturate, 11 sub-saturate.
- REQ-009: a  input  WIDTH  operand A, two's complement.
- REQ-010: b  input  WIDTH  operand B, two's complement.
- REQ-011: out_valid  output  1  result presented.
- REQ-012: out_ready  input  1  consumer takes result this cycle.
- REQ-013: s  output  WIDTH  result.
- REQ-014: n, v, z, c  output  1 each  negative, signed overflow, zero, carry-out.
- REQ-015: clr_sticky  input  1  synchronous clear of ovf_sticky.
- REQ-016: ovf_sticky  output  1  set by any transferred result with v=1.

Function
- REQ-017: Subtract SHALL be computed as a + ~b + 1 on the same adder; c is the raw adder carry-out (sub: c=1 means no borrow).
- REQ-018: v SHALL be signed overflow of the raw sum: add: a,b same sign and sum sign differs; sub: a,b signs differ and sum sign differs from a.
- REQ-019: In ops 10/11 with SAT=1 and v=1, s SHALL be 0 followed by all ones (max positive) if a[WIDTH-1]=0, else 1 followed by all zeros (min negative); v and c still report the raw sum.
- REQ-020: With SAT=0, ops 10/11 SHALL behave exactly as 00/01.
- REQ-021: n = s[WIDTH-1] and z = (s==0) SHALL be computed on the final (possibly saturated) s.
- REQ-022: PIPE=2: stage 1 registers the lower WIDTH/2 sum bits and their carry plus the upper operand halves and op; stage 2 completes the upper half, saturation and flags.
- REQ-023: PIPE=1: full computation in one stage.
- REQ-024: A global advance enable en = ~out_valid | out_ready; in_ready SHALL equal en combinationally.
- REQ-025: Operands SHALL be accepted only when in_valid & in_ready; a stage valid bit loads the upstream valid bit when en=1; empty-stage bubbles are not collapsed.
- REQ-026: Latency SHALL be PIPE cycles from acceptance to out_valid with no stall; throughput one result per cycle.
- REQ-027: While out_valid=1 and out_ready=0, s, n, v, z, c, out_valid and all stage contents SHALL hold; results leave in acceptance order with no loss or duplication.
- REQ-028: ovf_sticky SHALL set on a cycle where out_valid & out_ready & v; clr_sticky clears it; simultaneous set and clear SHALL leave it 1.

Reset
- REQ-029: rst=1 SHALL immediately clear out_valid, all stage valid bits, s, n, v, z, c and ovf_sticky to 0, independent of clk.
- REQ-030: Reset mid-operation SHALL discard all in-flight results; no pre-reset result appears after release; in_ready is 1 during and after reset.

Verification (WIDTH=16, PIPE=2, SAT=1, out_ready=1 unless stated)
- REQ-031: op=00, a=0x7FFF, b=0x0001 -> two cycles later s=0x8000, n=1, v=1, z=0, c=0, ovf_sticky=1 next cycle.
- REQ-032: op=10, a=0x7FFF, b=0x0001 -> s=0x7FFF, n=0, v=1; op=11, a=0x8000, b=0x0001 -> s=0x8000, n=1, v=1.
- REQ-033: op=01, a=0x1234, b=0x1234 -> s=0x0000, z=1, c=1, v=0; op=00, a=0x00FF, b=0x0001 -> s=0x0100 (split carry).
- REQ-034: four back-to-back ops, out_ready=0 for 3 cycles after first out_valid -> in_ready=0, s held, then all four results in order, none dropped.
- REQ-035: clr_sticky=1 on the same cycle an overflowing result transfers -> ovf_sticky=1; clr_sticky alone next cycle -> 0.
- REQ-036: rst pulsed with two ops in flight -> out_valid=0 at once, no out_valid for old ops after release; next op returns correctly after 2 cycles.
